// File: rtl/segment_write_arbiter.sv
// Round-robin arbiter for the segment register file write port, with a per-segment pending-write scoreboard.
// Optional build macro SEG_CS_PRIORITY_EN: a control request targeting CS always wins arbitration.
module segment_write_arbiter #(
  parameter int CNT_W  = 2,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [2:0]        wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              ctl_valid,
  input  logic [2:0]        ctl_sel,
  input  logic [DATA_W-1:0] ctl_data,
  output logic              ctl_ready,
  input  logic              mark_valid,
  input  logic [2:0]        mark_sel,
  output logic              mark_ready,
  input  logic              flush,
  output logic [2:0]        seg_write_select,
  output logic [DATA_W-1:0] seg_write_data,
  output logic              seg_write_enable,
  output logic [7:0]        seg_busy,
  output logic              sel_err
);

  localparam logic [0:0]       RR_WB   = 1'b0;
  localparam logic [0:0]       RR_CTL  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [0:0]        rr_q, rr_d;
  logic [2:0]        sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              en_q, en_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q [6];
  logic [CNT_W-1:0]  cnt_d [6];

  logic              cs_win_s;
  logic              wb_acc_s, ctl_acc_s;
  logic              mark_sat_s, mark_acc_s;
  logic [5:0]        inc_s, dec_s;

  // Arbitration: readiness, grant and round-robin pointer update
  always_comb begin
`ifdef SEG_CS_PRIORITY_EN
    cs_win_s = ctl_valid && (ctl_sel == 3'd1);
`else
    cs_win_s = 1'b0;
`endif
    wb_ready  = !cs_win_s && (!ctl_valid || (rr_q == RR_WB));
    ctl_ready = cs_win_s || !wb_valid || (rr_q == RR_CTL);
    wb_acc_s  = wb_valid && wb_ready;
    ctl_acc_s = ctl_valid && ctl_ready;
    if (wb_valid && ctl_valid && !cs_win_s) begin
      rr_d = ~rr_q;
    end else begin
      rr_d = rr_q;
    end
  end

  // Next write-port contents; select/data hold when nothing is accepted
  always_comb begin
    sel_d  = sel_q;
    data_d = data_q;
    en_d   = 1'b0;
    err_d  = 1'b0;
    if (ctl_acc_s) begin
      sel_d  = ctl_sel;
      data_d = ctl_data;
      en_d   = (ctl_sel < 3'd6);
      err_d  = (ctl_sel >= 3'd6);
    end else if (wb_acc_s) begin
      sel_d  = wb_sel;
      data_d = wb_data;
      en_d   = (wb_sel < 3'd6);
      err_d  = (wb_sel >= 3'd6);
    end else begin
      en_d   = 1'b0;
      err_d  = 1'b0;
    end
  end

  // Mark acceptance: segments 6/7 never exist, saturated counters refuse
  always_comb begin
    mark_sat_s = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (mark_sel == 3'(i)) begin
        mark_sat_s = (cnt_q[i] == CNT_MAX);
      end else begin
        mark_sat_s = mark_sat_s;
      end
    end
    mark_ready = !mark_sat_s;
    mark_acc_s = mark_valid && mark_ready;
  end

  // Scoreboard next state; a commit is the write currently on the port
  always_comb begin
    inc_s = 6'b000000;
    dec_s = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      inc_s[i] = mark_acc_s && (mark_sel == 3'(i));
      dec_s[i] = en_q && (sel_q == 3'(i));
      if (flush) begin
        cnt_d[i] = CNT_ZERO;
      end else if (inc_s[i] && !dec_s[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (dec_s[i] && !inc_s[i] && (cnt_q[i] != CNT_ZERO)) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Busy flags derived from the registered counters
  always_comb begin
    seg_busy = 8'h00;
    for (int i = 0; i < 6; i++) begin
      seg_busy[i] = (cnt_q[i] != CNT_ZERO);
    end
  end

  // State registers; reset also kills any write in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q   <= RR_WB;
      sel_q  <= 3'd0;
      data_q <= {DATA_W{1'b0}};
      en_q   <= 1'b0;
      err_q  <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      rr_q   <= rr_d;
      sel_q  <= sel_d;
      data_q <= data_d;
      en_q   <= en_d;
      err_q  <= err_d;
      for (int i = 0; i < 6; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign seg_write_select = sel_q;
  assign seg_write_data   = data_q;
  assign seg_write_enable = en_q;
  assign sel_err          = err_q;

endmodule

// File: tb/tb_segment_write_arbiter.sv
// Randomized self-checking bench for segment_write_arbiter against a behavioural model.
module tb_segment_write_arbiter;

  localparam int MAXC = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, ctl_valid, mark_valid, flush;
  logic [2:0]  wb_sel, ctl_sel, mark_sel;
  logic [15:0] wb_data, ctl_data;
  logic        wb_ready, ctl_ready, mark_ready;
  logic [2:0]  seg_write_select;
  logic [15:0] seg_write_data;
  logic        seg_write_enable;
  logic [7:0]  seg_busy;
  logic        sel_err;

  int n_chk  = 0;
  int n_pass = 0;

  // model state
  int fav;          // 0: wb favoured on a tie, 1: ctl favoured
  int m_cnt [6];
  bit m_en, m_err;
  int m_sel, m_data;

  always #5 clk = ~clk;

  segment_write_arbiter dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_data(wb_data), .wb_ready(wb_ready),
    .ctl_valid(ctl_valid), .ctl_sel(ctl_sel), .ctl_data(ctl_data), .ctl_ready(ctl_ready),
    .mark_valid(mark_valid), .mark_sel(mark_sel), .mark_ready(mark_ready),
    .flush(flush),
    .seg_write_select(seg_write_select), .seg_write_data(seg_write_data),
    .seg_write_enable(seg_write_enable), .seg_busy(seg_busy), .sel_err(sel_err)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    fav = 0;
    for (int i = 0; i < 6; i++) m_cnt[i] = 0;
    m_en = 0; m_err = 0; m_sel = 0; m_data = 0;
  endtask

  function automatic logic [7:0] exp_busy();
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 6; i++) b[i] = (m_cnt[i] > 0);
    return b;
  endfunction

  // One clock cycle: called at a falling edge, returns at the next falling edge.
  task automatic step(input bit wv, input int ws, input int wd,
                      input bit cv, input int cs, input int cd,
                      input bit mv, input int ms, input bit fl);
    bit cs_win, mr, inc, dec;
    int grant, sel;
    bit exp_wr, exp_cr;
    wb_valid = wv; wb_sel = 3'(ws); wb_data = 16'(wd);
    ctl_valid = cv; ctl_sel = 3'(cs); ctl_data = 16'(cd);
    mark_valid = mv; mark_sel = 3'(ms); flush = fl;
    #1;
    cs_win = 0;
`ifdef SEG_CS_PRIORITY_EN
    cs_win = cv && (cs == 1);
`endif
    if (cs_win)        grant = 2;
    else if (wv && cv) grant = (fav == 0) ? 1 : 2;
    else if (wv)       grant = 1;
    else if (cv)       grant = 2;
    else               grant = 0;
    // ready means "would be granted if this side were valid"
    exp_wr = !cs_win && (!cv || fav == 0);
    exp_cr = cs_win || !wv || fav == 1;
    mr = (ms < 6) ? (m_cnt[ms] < MAXC) : 1'b0;
    check_val("wb_ready", {31'd0, wb_ready}, {31'd0, exp_wr});
    check_val("ctl_ready", {31'd0, ctl_ready}, {31'd0, exp_cr});
    check_val("mark_ready", {31'd0, mark_ready}, {31'd0, mr});
    for (int i = 0; i < 6; i++) begin
      inc = mv && mr && (ms == i);
      dec = m_en && (m_sel == i);
      if (fl) m_cnt[i] = 0;
      else if (inc && !dec) m_cnt[i] = m_cnt[i] + 1;
      else if (dec && !inc && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
    end
    if (wv && cv && !cs_win) fav = 1 - fav;
    if (grant != 0) begin
      sel = (grant == 1) ? ws : cs;
      m_sel = sel;
      m_data = (grant == 1) ? wd : cd;
      m_en = (sel < 6);
      m_err = (sel >= 6);
    end else begin
      m_en = 0; m_err = 0;
    end
    @(posedge clk);
    #1;
    check_val("wr_enable", {31'd0, seg_write_enable}, {31'd0, m_en});
    check_val("sel_err", {31'd0, sel_err}, {31'd0, m_err});
    check_val("wr_select", {29'd0, seg_write_select}, 32'(m_sel));
    check_val("wr_data", {16'd0, seg_write_data}, 32'(m_data));
    check_val("seg_busy", {24'd0, seg_busy}, {24'd0, exp_busy()});
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    wb_valid = 0; wb_sel = 0; wb_data = 0;
    ctl_valid = 0; ctl_sel = 0; ctl_data = 0;
    mark_valid = 0; mark_sel = 0; flush = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_val("rst_enable", {31'd0, seg_write_enable}, 32'd0);
    check_val("rst_select", {29'd0, seg_write_select}, 32'd0);
    check_val("rst_data", {16'd0, seg_write_data}, 32'd0);
    check_val("rst_err", {31'd0, sel_err}, 32'd0);
    check_val("rst_busy", {24'd0, seg_busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // single wb write to DS
    step(1, 3, 16'h1234, 0, 0, 0, 0, 0, 0);
    check_val("first_wr_data", {16'd0, seg_write_data}, 32'h1234);
    check_val("first_wr_sel", {29'd0, seg_write_select}, 32'd3);
    idle();

    // four-cycle tie: wb, ctl, wb, ctl
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 16'hA000 + k, 1, 5, 16'hC000 + k, 0, 0, 0);
      check_val("tie_order_sel", {29'd0, seg_write_select}, (k % 2 == 0) ? 32'd0 : 32'd5);
    end
    idle();

    // saturate DS, drain it, then mark+commit in the same cycle
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 0, 1, 3, 0);
    check_val("ds_busy_sat", {31'd0, seg_busy[3]}, 32'd1);
    for (int k = 0; k < 3; k++) step(1, 3, 16'h0D00 + k, 0, 0, 0, 0, 0, 0);
    idle();
    check_val("ds_busy_drained", {31'd0, seg_busy[3]}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 1, 3, 0);
    step(1, 3, 16'h0D10, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 3, 0);
    check_val("ds_mark_commit", {31'd0, seg_busy[3]}, 32'd1);

    // illegal select from ctl
    step(0, 0, 0, 1, 7, 16'hBEEF, 0, 0, 0);
    check_val("sel7_err", {31'd0, sel_err}, 32'd1);
    idle();

    // flush with mark and commit in flight; new write still lands
    step(0, 0, 0, 0, 0, 0, 1, 2, 0);
    step(1, 2, 16'h2222, 0, 0, 0, 0, 0, 0);
    step(1, 4, 16'h4444, 0, 0, 0, 1, 2, 1);
    check_val("flush_busy", {24'd0, seg_busy}, 32'd0);
    check_val("flush_inflight_en", {31'd0, seg_write_enable}, 32'd1);
    idle();

    // CS tie right after reset (rr favours wb)
    reset = 1'b1; #1; reset = 1'b0; model_reset();
    step(1, 3, 16'h3333, 1, 1, 16'h1111, 0, 0, 0);
`ifdef SEG_CS_PRIORITY_EN
    check_val("cs_tie_sel", {29'd0, seg_write_select}, 32'd1);
`else
    check_val("cs_tie_sel", {29'd0, seg_write_select}, 32'd3);
`endif

    // reset mid-flight kills the pending enable immediately
    step(1, 0, 16'h5555, 0, 0, 0, 1, 0, 0);
    reset = 1'b1; #1;
    check_val("async_rst_en", {31'd0, seg_write_enable}, 32'd0);
    check_val("async_rst_busy", {24'd0, seg_busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // randomized traffic
    for (int k = 0; k < 2000; k++) begin
      int ws, cs;
      ws = ($urandom_range(0, 7) == 0) ? 6 + $urandom_range(0, 1) : $urandom_range(0, 5);
      cs = ($urandom_range(0, 7) == 0) ? 6 + $urandom_range(0, 1) : $urandom_range(0, 5);
      step($urandom_range(0, 1), ws, $urandom_range(0, 65535),
           $urandom_range(0, 1), cs, $urandom_range(0, 65535),
           $urandom_range(0, 3) != 0, $urandom_range(0, 7),
           $urandom_range(0, 31) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
